param_serial_adder: RTL and testbench



---
 rtl/param_serial_adder_pkg.sv | 14 +
 rtl/param_chunk_adder.sv | 14 +
 rtl/param_serial_adder.sv | 97 +++++++++
 tb/tb_param_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/param_serial_adder_pkg.sv
// param_serial_adder_pkg: shared FSM state type and chunk-count helpers
package param_serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int width, input int chunk);
        return (width / chunk) > 1 ? $clog2(width / chunk) : 1;
    endfunction

endpackage

// File: rtl/param_chunk_adder.sv
// param_chunk_adder: combinational CHUNK-bit adder with carry in/out
module param_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/param_serial_adder.sv
// param_serial_adder: chunk-serial a + b + cin behind valid/ready handshakes
module param_serial_adder
    import param_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("param_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CHUNK-1:0] cs;
    logic             cs_co;

    param_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_sh[CHUNK-1:0]),
        .y  (b_sh[CHUNK-1:0]),
        .ci (carry),
        .s  (cs),
        .co (cs_co)
    );

    // New chunk enters at the MSB end so the LSB chunk lands at bit 0 after NCHUNK steps
    assign sum_nx    = WIDTH'({cs, sum_sh} >> CHUNK);
    assign in_ready  = state == IDLE && !rst;
    assign out_valid = state == HOLD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= cin;
                    a_msb <= a[WIDTH-1];
                    b_msb <= b[WIDTH-1];
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    sum_sh <= sum_nx;
                    carry  <= cs_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NCHUNK - 1)) begin
                        state <= HOLD;
                        sum   <= sum_nx;
                        cout  <= cs_co;
                        ovf   <= a_msb == b_msb && sum_nx[WIDTH-1] != a_msb;
                    end
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_serial_adder.sv
// tb_param_serial_adder: scoreboard bench with directed cases and random traffic
module tb_param_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   rnd_bp = 0;
    exp_t q[$];

    param_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        int   u;
        int   sg;
        exp_t e;
        u   = int'(x) + int'(y) + int'(c);
        sg  = int'($signed(x)) + int'($signed(y)) + int'(c);
        e.s = 8'(u % 256);
        e.c = u >= 256;
        e.o = sg > 127 || sg < -128;
        return e;
    endfunction

    // Monitor: every delivered result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.o));
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        q.push_back(model(x, y, c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        @(posedge clk);
        #1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic directed(input logic [7:0] x, input logic [7:0] y, input logic c);
        int lat;
        send(x, y, c);
        wait_valid(lat);
        check("latency", 32'(lat), 32'd4);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        directed(8'h2A, 8'h15, 1'b0);
        directed(8'hFF, 8'h01, 1'b0);
        directed(8'h7F, 8'h01, 1'b0);
        directed(8'h80, 8'h80, 1'b0);
        directed(8'hF6, 8'h0F, 1'b0);
        directed(8'h10, 8'h0F, 1'b1);

        out_ready = 1'b0;
        send(8'h33, 8'h44, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'h11;
            b = 8'h22;
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h77);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;

        send(8'h0F, 8'h0F, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        void'(q.pop_back());
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout_ovf", 32'({cout, ovf}), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        directed(8'h01, 8'h01, 1'b0);

        rnd_bp = 1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        rnd_bp = 0;
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        check("drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
